// File: rtl/cov_tlb_event_monitor.sv
// TLB tag-array coverage monitor: detects per-entry fill/invalidate/replace,
// queues one event record per cycle for samplers and keeps saturating totals.
module cov_tlb_event_monitor #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned ASID_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     en_i,
  input  logic [TLB_ENTRIES*(ASID_WIDTH+30)-1:0]   tags_i,
  output logic                                     evt_valid_o,
  input  logic                                     evt_ready_i,
  output logic [1:0]                               evt_kind_o,
  output logic [$clog2(TLB_ENTRIES)-1:0]           evt_idx_o,
  output logic [ASID_WIDTH-1:0]                    evt_asid_o,
  output logic [26:0]                              evt_vpn_o,
  output logic [1:0]                               evt_size_o,
  output logic [CNT_W-1:0]                         cnt_fill_o,
  output logic [CNT_W-1:0]                         cnt_inval_o,
  output logic [CNT_W-1:0]                         cnt_replace_o,
  output logic [CNT_W-1:0]                         cnt_drop_o,
  output logic                                     overflow_o,
  output logic [$clog2(TLB_ENTRIES):0]             occupancy_o
);

  localparam int unsigned EW     = ASID_WIDTH + 30;
  localparam int unsigned IDX_W  = $clog2(TLB_ENTRIES);
  localparam int unsigned OCC_W  = IDX_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    EVT_FILL    = 2'd0,
    EVT_INVAL   = 2'd1,
    EVT_REPLACE = 2'd2,
    EVT_FLUSH   = 2'd3
  } evt_kind_e;

  typedef struct packed {
    evt_kind_e             kind;
    logic [IDX_W-1:0]      idx;
    logic [ASID_WIDTH-1:0] asid;
    logic [26:0]           vpn;
    logic [1:0]            size;
  } evt_rec_t;

  logic [TLB_ENTRIES*EW-1:0] prev_tags;
  logic                      primed;

  logic [TLB_ENTRIES-1:0] fill_vec, inval_vec, repl_vec;
  logic [OCC_W-1:0]       n_fill, n_inval, n_repl, n_chg, n_valid;
  logic [EW-1:0]          sel_tag;
  logic [IDX_W-1:0]       sel_idx;
  evt_kind_e              sel_kind;
  logic                   det_flush, det_active, det_push;
  logic [OCC_W-1:0]       drop_multi, drop_inc;
  evt_rec_t               det_rec;

  logic                   pend_valid;
  evt_rec_t               pend_rec;

  evt_rec_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]      fcnt;
  logic                   fifo_full, do_pop, do_push, push_drop;
  evt_rec_t               head;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [OCC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Per-entry change classification and population counts
  always_comb begin
    fill_vec  = '0;
    inval_vec = '0;
    repl_vec  = '0;
    n_fill    = '0;
    n_inval   = '0;
    n_repl    = '0;
    n_valid   = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      fill_vec[i]  = !prev_tags[i*EW] && tags_i[i*EW];
      inval_vec[i] = prev_tags[i*EW] && !tags_i[i*EW];
      repl_vec[i]  = prev_tags[i*EW] && tags_i[i*EW] &&
                     (prev_tags[i*EW+1 +: EW-1] != tags_i[i*EW+1 +: EW-1]);
      n_fill  = n_fill  + OCC_W'(fill_vec[i]);
      n_inval = n_inval + OCC_W'(inval_vec[i]);
      n_repl  = n_repl  + OCC_W'(repl_vec[i]);
      n_valid = n_valid + OCC_W'(tags_i[i*EW]);
    end
    n_chg = n_fill + n_inval + n_repl;
  end

  // Lowest-index change wins; INVAL reports the departing tag
  always_comb begin
    sel_tag  = '0;
    sel_idx  = '0;
    sel_kind = EVT_FILL;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (fill_vec[i] || inval_vec[i] || repl_vec[i]) begin
        sel_idx  = IDX_W'(i);
        sel_kind = inval_vec[i] ? EVT_INVAL : (fill_vec[i] ? EVT_FILL : EVT_REPLACE);
        sel_tag  = inval_vec[i] ? prev_tags[i*EW +: EW] : tags_i[i*EW +: EW];
      end
    end
    det_active = en_i && primed;
    det_push   = det_active && (n_chg != '0);
    det_flush  = (n_chg > OCC_W'(1)) && (n_chg == n_inval);
    det_rec    = '{kind: sel_kind, idx: sel_idx, asid: sel_tag[EW-1:30],
                   vpn: sel_tag[29:3], size: {sel_tag[1], sel_tag[2]}};
    if (det_flush) begin
      det_rec      = '0;
      det_rec.kind = EVT_FLUSH;
      det_rec.idx  = IDX_W'(n_chg - OCC_W'(1));
    end
    drop_multi = (det_push && !det_flush) ? n_chg - OCC_W'(1) : '0;
  end

  // FIFO handshake; a pop frees the slot for a same-cycle push when full
  always_comb begin
    fifo_full = (fcnt == FCNT_W'(FIFO_DEPTH));
    do_pop    = (fcnt != '0) && evt_ready_i;
    do_push   = pend_valid && (!fifo_full || do_pop);
    push_drop = pend_valid && fifo_full && !do_pop;
    drop_inc  = drop_multi + OCC_W'(push_drop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_tags     <= '0;
      primed        <= 1'b0;
      occupancy_o   <= '0;
      pend_valid    <= 1'b0;
      pend_rec      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcnt          <= '0;
      cnt_fill_o    <= '0;
      cnt_inval_o   <= '0;
      cnt_replace_o <= '0;
      cnt_drop_o    <= '0;
      overflow_o    <= 1'b0;
    end else begin
      if (en_i) begin
        prev_tags   <= tags_i;
        primed      <= 1'b1;
        occupancy_o <= n_valid;
      end else begin
        primed <= 1'b0;
      end
      pend_valid <= det_push;
      pend_rec   <= det_rec;
      if (det_active) begin
        cnt_fill_o    <= sat_add(cnt_fill_o, n_fill);
        cnt_inval_o   <= sat_add(cnt_inval_o, n_inval);
        cnt_replace_o <= sat_add(cnt_replace_o, n_repl);
      end
      cnt_drop_o <= sat_add(cnt_drop_o, drop_inc);
      if (push_drop) overflow_o <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fcnt <= fcnt + FCNT_W'(do_push) - FCNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= pend_rec;
  end

  // Head fields read straight from storage, forced to zero when empty
  always_comb begin
    head        = mem[rd_ptr];
    evt_valid_o = (fcnt != '0);
    evt_kind_o  = evt_valid_o ? head.kind : 2'd0;
    evt_idx_o   = evt_valid_o ? head.idx  : '0;
    evt_asid_o  = evt_valid_o ? head.asid : '0;
    evt_vpn_o   = evt_valid_o ? head.vpn  : '0;
    evt_size_o  = evt_valid_o ? head.size : '0;
  end

endmodule

// File: tb/tb_cov_tlb_event_monitor.sv
// Bench for cov_tlb_event_monitor: directed scenarios plus random tag traffic
// compared cycle by cycle with an event-list reference model.
module tb_cov_tlb_event_monitor;

  localparam int N      = 16;
  localparam int ASID_W = 16;
  localparam int FD     = 8;
  localparam int CNT_W  = 8;
  localparam int EW     = ASID_W + 30;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              ready = 1'b0;
  logic [N*EW-1:0]   tags = '0;
  logic              evt_valid;
  logic [1:0]        evt_kind;
  logic [3:0]        evt_idx;
  logic [ASID_W-1:0] evt_asid;
  logic [26:0]       evt_vpn;
  logic [1:0]        evt_size;
  logic [CNT_W-1:0]  cnt_fill, cnt_inval, cnt_replace, cnt_drop;
  logic              overflow;
  logic [4:0]        occupancy;

  cov_tlb_event_monitor #(
    .TLB_ENTRIES(N), .ASID_WIDTH(ASID_W), .FIFO_DEPTH(FD), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tags_i(tags),
    .evt_valid_o(evt_valid), .evt_ready_i(ready),
    .evt_kind_o(evt_kind), .evt_idx_o(evt_idx), .evt_asid_o(evt_asid),
    .evt_vpn_o(evt_vpn), .evt_size_o(evt_size),
    .cnt_fill_o(cnt_fill), .cnt_inval_o(cnt_inval),
    .cnt_replace_o(cnt_replace), .cnt_drop_o(cnt_drop),
    .overflow_o(overflow), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int idx;
    int asid;
    int vpn;
    int size;
  } mrec_t;

  logic [EW-1:0] t [N];
  logic [EW-1:0] m_prev [N];
  bit            m_primed, m_pend, m_over;
  mrec_t         m_pend_rec;
  mrec_t         m_q [$];
  int            m_fill, m_inval, m_repl, m_drop, m_occ;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic [EW-1:0] mk(input logic v, input logic g1, input logic m2,
                                       input logic [26:0] vpn, input logic [ASID_W-1:0] asid);
    return {asid, vpn, m2, g1, v};
  endfunction

  function automatic logic [EW-1:0] rand_tag(input logic v);
    return mk(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              27'($urandom), 16'($urandom_range(0, 3)));
  endfunction

  // Model of one clock edge, from the inputs currently driven
  task automatic model_update();
    int nf, ni, nr, tot, first, fk, k, occ;
    logic [EW-1:0] src;
    if (rst) begin
      m_q.delete();
      m_pend = 0; m_primed = 0; m_over = 0;
      m_fill = 0; m_inval = 0; m_repl = 0; m_drop = 0; m_occ = 0;
      for (int i = 0; i < N; i++) m_prev[i] = '0;
      return;
    end
    if (m_q.size() > 0 && ready) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < FD) m_q.push_back(m_pend_rec);
      else begin
        m_over = 1;
        m_drop = sat(m_drop + 1);
      end
    end
    m_pend = 0;
    if (en) begin
      if (m_primed) begin
        nf = 0; ni = 0; nr = 0; first = -1; fk = 0;
        for (int i = 0; i < N; i++) begin
          k = -1;
          if (!m_prev[i][0] && t[i][0]) begin k = 0; nf++; end
          else if (m_prev[i][0] && !t[i][0]) begin k = 1; ni++; end
          else if (m_prev[i][0] && t[i][0] && m_prev[i] != t[i]) begin k = 2; nr++; end
          if (k >= 0 && first < 0) begin first = i; fk = k; end
        end
        m_fill = sat(m_fill + nf);
        m_inval = sat(m_inval + ni);
        m_repl = sat(m_repl + nr);
        tot = nf + ni + nr;
        if (tot >= 2 && ni == tot) begin
          m_pend = 1;
          m_pend_rec = '{kind: 3, idx: tot - 1, asid: 0, vpn: 0, size: 0};
        end else if (tot >= 1) begin
          src = (fk == 1) ? m_prev[first] : t[first];
          m_pend = 1;
          m_pend_rec = '{kind: fk, idx: first, asid: int'(src[EW-1:30]),
                         vpn: int'(src[29:3]), size: int'(src[1]) * 2 + int'(src[2])};
          m_drop = sat(m_drop + tot - 1);
        end
      end
      occ = 0;
      for (int i = 0; i < N; i++) begin
        m_prev[i] = t[i];
        occ += int'(t[i][0]);
      end
      m_occ = occ;
      m_primed = 1;
    end else begin
      m_primed = 0;
    end
  endtask

  task automatic compare_all();
    check("valid", 64'(evt_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("kind", 64'(evt_kind), 64'(m_q[0].kind));
      check("idx", 64'(evt_idx), 64'(m_q[0].idx));
      check("asid", 64'(evt_asid), 64'(m_q[0].asid));
      if (m_q[0].kind != 3) begin
        check("vpn", 64'(evt_vpn), 64'(m_q[0].vpn));
        check("size", 64'(evt_size), 64'(m_q[0].size));
      end
    end
    check("cnt_fill", 64'(cnt_fill), 64'(m_fill));
    check("cnt_inval", 64'(cnt_inval), 64'(m_inval));
    check("cnt_replace", 64'(cnt_replace), 64'(m_repl));
    check("cnt_drop", 64'(cnt_drop), 64'(m_drop));
    check("overflow", 64'(overflow), 64'(m_over));
    check("occupancy", 64'(occupancy), 64'(m_occ));
  endtask

  task automatic step();
    for (int i = 0; i < N; i++) tags[i*EW +: EW] = t[i];
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_tags();
    for (int i = 0; i < N; i++) t[i] = '0;
  endtask

  task automatic do_reset();
    clear_tags();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic mutate();
    int e;
    e = $urandom_range(0, N - 1);
    case ($urandom_range(0, 9))
      0, 1, 2: t[e] = rand_tag(1'($urandom_range(0, 1)));
      3, 4:    if (t[e][0]) t[e][29:3] = 27'($urandom); else t[e] = rand_tag(1'b1);
      5:       repeat ($urandom_range(2, 4)) t[$urandom_range(0, N - 1)] = rand_tag(1'($urandom_range(0, 1)));
      6:       for (int i = 0; i < N; i++) t[i][0] = 1'b0;
      7:       if (!t[e][0]) t[e] = rand_tag(1'b0);
      default: ;
    endcase
  endtask

  initial begin
    int pops;
    clear_tags();

    // Reset state
    do_reset();
    check("rst_valid", 64'(evt_valid), 64'(0));
    check("rst_cnt_fill", 64'(cnt_fill), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));

    // Single fill on entry 5
    en = 1'b1; ready = 1'b0;
    step();
    t[5] = mk(1'b1, 1'b0, 1'b1, 27'h1ABCDEF, 16'h12);
    step();
    check("t1_valid_early", 64'(evt_valid), 64'(0));
    check("t1_cnt_fill", 64'(cnt_fill), 64'(1));
    step();
    check("t1_valid", 64'(evt_valid), 64'(1));
    check("t1_kind", 64'(evt_kind), 64'(0));
    check("t1_idx", 64'(evt_idx), 64'(5));
    check("t1_asid", 64'(evt_asid), 64'(16'h12));
    check("t1_vpn", 64'(evt_vpn), 64'(27'h1ABCDEF));
    check("t1_size", 64'(evt_size), 64'(1));
    check("t1_occ", 64'(occupancy), 64'(1));
    ready = 1'b1;
    step();
    check("t1_popped", 64'(evt_valid), 64'(0));

    // Full flush of 16 valid entries
    do_reset();
    for (int i = 0; i < N; i++) t[i] = rand_tag(1'b1);
    step();
    check("t2_occ", 64'(occupancy), 64'(16));
    for (int i = 0; i < N; i++) t[i][0] = 1'b0;
    ready = 1'b0;
    step();
    step();
    check("t2_kind", 64'(evt_kind), 64'(3));
    check("t2_idx", 64'(evt_idx), 64'(15));
    check("t2_asid", 64'(evt_asid), 64'(0));
    check("t2_cnt_inval", 64'(cnt_inval), 64'(16));
    check("t2_cnt_drop", 64'(cnt_drop), 64'(0));

    // Mixed fill / replace / inval in one cycle
    do_reset();
    t[7] = rand_tag(1'b1);
    t[9] = rand_tag(1'b1);
    step();
    t[3] = rand_tag(1'b1);
    t[7][29:3] = t[7][29:3] ^ 27'h1;
    t[9][0] = 1'b0;
    step();
    step();
    check("t3_kind", 64'(evt_kind), 64'(0));
    check("t3_idx", 64'(evt_idx), 64'(3));
    check("t3_fill", 64'(cnt_fill), 64'(1));
    check("t3_repl", 64'(cnt_replace), 64'(1));
    check("t3_inval", 64'(cnt_inval), 64'(1));
    check("t3_drop", 64'(cnt_drop), 64'(2));

    // Overflow: nine fills with the consumer stalled
    do_reset();
    ready = 1'b0;
    step();
    for (int k = 0; k < 9; k++) begin
      t[k] = rand_tag(1'b1);
      step();
    end
    step();
    step();
    check("t4_overflow", 64'(overflow), 64'(1));
    check("t4_drop", 64'(cnt_drop), 64'(1));
    ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 12 && evt_valid; k++) begin
      check("t4_order", 64'(evt_idx), 64'(k));
      step();
      pops++;
    end
    check("t4_pops", 64'(pops), 64'(8));
    check("t4_empty", 64'(evt_valid), 64'(0));

    // Push and pop together while full
    do_reset();
    ready = 1'b0;
    step();
    for (int k = 0; k < 9; k++) begin
      t[k] = rand_tag(1'b1);
      step();
    end
    ready = 1'b1;
    step();
    check("t5_overflow", 64'(overflow), 64'(0));
    check("t5_drop", 64'(cnt_drop), 64'(0));
    check("t5_head", 64'(evt_idx), 64'(1));
    pops = 0;
    for (int k = 0; k < 12 && evt_valid; k++) begin
      check("t5_order", 64'(evt_idx), 64'(k + 1));
      step();
      pops++;
    end
    check("t5_pops", 64'(pops), 64'(8));

    // Disable hides a change; reset discards queued records
    do_reset();
    ready = 1'b1;
    step();
    en = 1'b0;
    t[2] = rand_tag(1'b1);
    step();
    step();
    en = 1'b1;
    step();
    step();
    check("t6_no_evt", 64'(evt_valid), 64'(0));
    check("t6_no_fill", 64'(cnt_fill), 64'(0));
    check("t6_occ", 64'(occupancy), 64'(1));
    ready = 1'b0;
    t[4] = rand_tag(1'b1);
    step();
    step();
    check("t6_queued", 64'(evt_valid), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", 64'(evt_valid), 64'(0));
    check("t6_rst_fill", 64'(cnt_fill), 64'(0));
    check("t6_rst_drop", 64'(cnt_drop), 64'(0));
    check("t6_rst_occ", 64'(occupancy), 64'(0));

    // Random traffic against the model, long enough to saturate counters
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 19) != 0);
      ready = ($urandom_range(0, 9) < 6);
      mutate();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
